// File: rtl/mem_arb_pkg.sv
// ============================================================================
// Module      : mem_arb_pkg
// Description : Shared types and constants for the two-port SRAM arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_arb_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;
  localparam int BE_W_DEF   = DATA_W_DEF / 8;

  localparam int PORT_CORE = 0;
  localparam int PORT_AUX  = 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  // Command captured from the winning port; field widths follow the defaults.
  typedef struct packed {
    logic                  we;
    logic [ADDR_W_DEF-1:0] addr;
    logic [DATA_W_DEF-1:0] wdata;
    logic [BE_W_DEF-1:0]   be;
  } cmd_t;

endpackage

`default_nettype wire

// File: rtl/mem_arbiter_arb_pick.sv
// ============================================================================
// Module      : arb_pick
// Description : Combinational winner select for two requesters.
//               ARB_ROUND_ROBIN_EN: ties go to the port other than last_grant;
//               otherwise the core port (0) always wins ties.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module arb_pick
  import mem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       valid,
  output logic       winner
);

`ifndef ARB_ROUND_ROBIN_EN
  // History is tracked by the top even when ties are resolved by priority.
  logic unused_last_grant;
  assign unused_last_grant = last_grant;
`endif

  always_comb begin
    valid  = |req;
    winner = 1'(PORT_CORE);
    if (req == 2'b10) begin
      winner = 1'(PORT_AUX);
    end else if (req == 2'b11) begin
`ifdef ARB_ROUND_ROBIN_EN
      winner = ~last_grant;
`else
      winner = 1'(PORT_CORE);
`endif
    end
  end

endmodule

`default_nettype wire

// File: rtl/mem_arbiter.sv
// ============================================================================
// Module      : mem_arbiter
// Description : Shares one single-ported SRAM between the core (port 0) and an
//               auxiliary master (port 1); IDLE -> ACCESS -> RESP per access.
//               Optional macro ARB_ROUND_ROBIN_EN selects round-robin ties.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [1:0]              m_req,
  input  logic [1:0]              m_we,
  input  logic [2*ADDR_W-1:0]     m_addr,
  input  logic [2*DATA_W-1:0]     m_wdata,
  input  logic [2*(DATA_W/8)-1:0] m_be,
  output logic [1:0]              m_gnt,
  output logic [1:0]              m_rvalid,
  output logic [DATA_W-1:0]       m_rdata,
  output logic                    sram_en,
  output logic                    sram_we,
  output logic [ADDR_W-1:0]       sram_addr,
  output logic [DATA_W-1:0]       sram_wdata,
  output logic [DATA_W/8-1:0]     sram_be,
  input  logic [DATA_W-1:0]       sram_rdata
);

  localparam int BE_W = DATA_W / 8;

  state_t state, state_nxt;
  cmd_t   cmd;
  logic   winner;
  logic   last_grant;
  logic   pick_valid;
  logic   pick_winner;

  arb_pick u_arb_pick (
    .req        (m_req),
    .last_grant (last_grant),
    .valid      (pick_valid),
    .winner     (pick_winner)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Command capture happens only on the IDLE sampling edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmd        <= '0;
      winner     <= 1'b0;
      last_grant <= 1'b1;
    end else if (state == IDLE && pick_valid) begin
      cmd.we     <= m_we[pick_winner];
      cmd.addr   <= m_addr[pick_winner*ADDR_W +: ADDR_W];
      cmd.wdata  <= m_wdata[pick_winner*DATA_W +: DATA_W];
      cmd.be     <= m_be[pick_winner*BE_W +: BE_W];
      winner     <= pick_winner;
      last_grant <= pick_winner;
    end
  end

  // Outputs decode from state and latched command only, never from m_* inputs.
  always_comb begin
    state_nxt  = state;
    m_gnt      = 2'b00;
    m_rvalid   = 2'b00;
    m_rdata    = '0;
    sram_en    = 1'b0;
    sram_we    = 1'b0;
    sram_addr  = '0;
    sram_wdata = '0;
    sram_be    = '0;
    case (state)
      IDLE: begin
        if (pick_valid) state_nxt = ACCESS;
      end
      ACCESS: begin
        sram_en        = 1'b1;
        sram_we        = cmd.we;
        sram_addr      = cmd.addr;
        sram_wdata     = cmd.wdata;
        sram_be        = cmd.be;
        m_gnt[winner]  = 1'b1;
        state_nxt      = RESP;
      end
      RESP: begin
        m_rvalid[winner] = 1'b1;
        m_rdata          = sram_rdata;
        state_nxt        = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// ============================================================================
// Module      : tb_mem_arbiter
// Description : Self-checking bench for mem_arbiter with a behavioural SRAM.
//               Build with ARB_ROUND_ROBIN_EN to match a round-robin DUT.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  m_req, m_we, m_gnt, m_rvalid;
  logic [63:0] m_addr, m_wdata;
  logic [7:0]  m_be;
  logic [31:0] m_rdata, sram_addr, sram_wdata, sram_rdata;
  logic        sram_en, sram_we;
  logic [3:0]  sram_be;

  mem_arbiter dut (
    .clk(clk), .rst(rst), .m_req(m_req), .m_we(m_we), .m_addr(m_addr),
    .m_wdata(m_wdata), .m_be(m_be), .m_gnt(m_gnt), .m_rvalid(m_rvalid),
    .m_rdata(m_rdata), .sram_en(sram_en), .sram_we(sram_we),
    .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_be(sram_be),
    .sram_rdata(sram_rdata)
  );

  always #5 clk = ~clk;

  // Behavioural SRAM: read data registered one cycle after sram_en.
  logic [31:0] mem [0:63];
  logic        pl_en;
  logic [5:0]  pl_idx;
  logic [31:0] pl_data;

  always @(posedge clk) begin
    if (pl_en) begin
      mem[pl_idx] <= pl_data;
    end else if (sram_en) begin
      if (sram_we) begin
        for (int b = 0; b < 4; b++)
          if (sram_be[b]) mem[sram_addr[7:2]][b*8 +: 8] <= sram_wdata[b*8 +: 8];
      end else begin
        sram_rdata <= mem[sram_addr[7:2]];
      end
    end
  end

  int n_cmp = 0;
  int n_fail = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at t=%0t", nm, act, exp, $time);
    end
  endtask

  typedef struct {
    int          port;
    logic        chk;
    logic [31:0] data;
  } sb_t;
  sb_t sbq[$];

  // Response monitor: pops the scoreboard on every rvalid pulse.
  logic prev_en = 1'b0;
  always @(negedge clk) begin
    sb_t e;
    if (rst) begin
      prev_en = 1'b0;
    end else begin
      if (sram_en) check("sram_en_gap", 32'(prev_en), 32'd0);
      prev_en = sram_en;
      if (m_rvalid != 2'b00) begin
        if (sbq.size() == 0) begin
          check("rvalid_unexpected", 32'(m_rvalid), 32'd0);
        end else begin
          e = sbq.pop_front();
          check("sb_rvalid_port", 32'(m_rvalid), 32'd1 << e.port);
          if (e.chk) check("sb_rdata", m_rdata, e.data);
        end
      end else begin
        check("rdata_idle_zero", m_rdata, 32'd0);
      end
    end
  end

  task automatic set_cmd(input int p, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] be);
    m_we[p]            = we;
    m_addr[p*32 +: 32] = addr;
    m_wdata[p*32 +: 32] = wdata;
    m_be[p*4 +: 4]     = be;
  endtask

  task automatic push(input int p, input logic we, input logic [31:0] exp_rd);
    sb_t e;
    e.port = p;
    e.chk  = !we;
    e.data = exp_rd;
    sbq.push_back(e);
  endtask

  // One uncontended transaction: called at a negedge with the FSM in IDLE.
  task automatic single(input int p, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] be,
                        input logic [31:0] exp_rd);
    int lat;
    push(p, we, exp_rd);
    set_cmd(p, we, addr, wdata, be);
    m_req[p] = 1'b1;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!m_gnt[p] && lat < 8);
    check("gnt_latency", 32'(lat), 32'd1);
    if (m_gnt[p]) begin
      check("sram_en", 32'(sram_en), 32'd1);
      check("sram_we", 32'(sram_we), 32'(we));
      check("sram_addr", sram_addr, addr);
      if (we) begin
        check("sram_wdata", sram_wdata, wdata);
        check("sram_be", 32'(sram_be), 32'(be));
      end
    end
    m_req[p] = 1'b0;
    @(negedge clk);
    check("rvalid_latency", 32'(m_rvalid), 32'd1 << p);
    @(negedge clk);
  endtask

  typedef struct {
    int          port;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] exp_rd;
  } vec_t;
  vec_t vecs[8];

  int ord[4];

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int g1, g2, ng, k;

    vecs[0] = '{0, 1'b0, 32'h10, 32'h0,        4'h0, 32'hDEADBEEF};
    vecs[1] = '{1, 1'b1, 32'h20, 32'h12345678, 4'hF, 32'h0};
    vecs[2] = '{0, 1'b0, 32'h20, 32'h0,        4'h0, 32'h12345678};
    vecs[3] = '{0, 1'b1, 32'h30, 32'hAABBCCDD, 4'h3, 32'h0};
    vecs[4] = '{1, 1'b0, 32'h30, 32'h0,        4'h0, 32'hFFFFCCDD};
    vecs[5] = '{1, 1'b1, 32'h40, 32'h40404040, 4'hF, 32'h0};
    vecs[6] = '{1, 1'b1, 32'h44, 32'h44444444, 4'hF, 32'h0};
    vecs[7] = '{0, 1'b1, 32'h24, 32'h11223344, 4'hC, 32'h0};

    rst = 1'b1; m_req = '0; m_we = '0; m_addr = '0; m_wdata = '0; m_be = '0;
    pl_en = 1'b1; pl_idx = '0; pl_data = '0;
    for (int i = 0; i < 64; i++) begin
      pl_idx = 6'(i);
      pl_data = (i == 4) ? 32'hDEADBEEF : (i == 12) ? 32'hFFFFFFFF : 32'h0;
      @(negedge clk);
    end
    pl_en = 1'b0;

    check("rst_m_gnt", 32'(m_gnt), 32'd0);
    check("rst_m_rvalid", 32'(m_rvalid), 32'd0);
    check("rst_m_rdata", m_rdata, 32'd0);
    check("rst_sram_en", 32'(sram_en), 32'd0);
    check("rst_sram_we", 32'(sram_we), 32'd0);
    check("rst_sram_addr", sram_addr, 32'd0);
    check("rst_sram_wdata", sram_wdata, 32'd0);
    check("rst_sram_be", 32'(sram_be), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 8; i++)
      single(vecs[i].port, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].be, vecs[i].exp_rd);
    single(1, 1'b0, 32'h24, 32'h0, 4'h0, 32'h11220000);

    // Back-to-back: port 0 keeps req high across two transactions.
    push(0, 1'b0, 32'hDEADBEEF);
    push(0, 1'b0, 32'h12345678);
    set_cmd(0, 1'b0, 32'h10, 32'h0, 4'h0);
    m_req[0] = 1'b1;
    ng = 0; g1 = 0; g2 = 0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (m_gnt[0]) begin
        ng++;
        if (ng == 1) begin
          g1 = c;
          set_cmd(0, 1'b0, 32'h20, 32'h0, 4'h0);
        end else begin
          g2 = c;
          m_req[0] = 1'b0;
        end
      end
    end
    m_req[0] = 1'b0;
    check("b2b_gnt_count", 32'(ng), 32'd2);
    check("b2b_gnt_spacing", 32'(g2 - g1), 32'd3);

    // Reset while in ACCESS: everything drops at once; request is reissued.
    set_cmd(0, 1'b0, 32'h10, 32'h0, 4'h0);
    m_req[0] = 1'b1;
    @(negedge clk);
    check("pre_rst_gnt", 32'(m_gnt), 32'd1);
    rst = 1'b1;
    #1;
    check("midrst_m_gnt", 32'(m_gnt), 32'd0);
    check("midrst_sram_en", 32'(sram_en), 32'd0);
    check("midrst_sram_addr", sram_addr, 32'd0);
    @(negedge clk);
    check("midrst_m_rvalid", 32'(m_rvalid), 32'd0);
    check("midrst_m_rdata", m_rdata, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    single(0, 1'b0, 32'h10, 32'h0, 4'h0, 32'hDEADBEEF);

    // Contention from a fresh reset, both ports requesting continuously.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
`ifdef ARB_ROUND_ROBIN_EN
    ord[0] = 0; ord[1] = 1; ord[2] = 0; ord[3] = 1;
`else
    ord[0] = 0; ord[1] = 0; ord[2] = 0; ord[3] = 0;
`endif
    for (int i = 0; i < 4; i++)
      push(ord[i], 1'b0, (ord[i] == 0) ? 32'h40404040 : 32'h44444444);
    set_cmd(0, 1'b0, 32'h40, 32'h0, 4'h0);
    set_cmd(1, 1'b0, 32'h44, 32'h0, 4'h0);
    m_req = 2'b11;
    k = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (m_gnt != 2'b00 && k < 4) begin
        check("contention_gnt", 32'(m_gnt), 32'd1 << ord[k]);
        k++;
        if (k == 4) m_req = 2'b00;
      end
    end
    m_req = 2'b00;
    check("contention_grants", 32'(k), 32'd4);

    repeat (3) @(negedge clk);
    check("sb_drained", 32'(sbq.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port memory arbiter sharing the single-ported SRAM between the OTTER core and a secondary bus master (program loader / test DMA) inside the top-level CPU wrapper. Accepts one transaction at a time from either requester, forwards it to the SRAM, and returns read data or a write acknowledge to the winner. A three-state FSM sequences each access: sample/arbitrate, SRAM access, response.

## Interface
- ADDR_W, 32, byte address width of requesters and SRAM
- DATA_W, 32, data width; byte-enable width is DATA_W/8
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- m_req  in  2  per-port request; bit 0 = core, bit 1 = secondary master
- m_we  in  2  per-port write enable (1 = write)
- m_addr  in  2×ADDR_W  per-port address (packed, port 0 in low bits)
- m_wdata  in  2×DATA_W  per-port write data
- m_be  in  2×DATA_W/8  per-port byte enables
- m_gnt  out  2  one-cycle pulse: command accepted and issued to SRAM
- m_rvalid  out  2  one-cycle pulse: response valid (read data or write ack)
- m_rdata  out  DATA_W  read data, shared, qualified by m_rvalid
- sram_en  out  1  SRAM access strobe
- sram_we  out  1  SRAM write enable
- sram_addr  out  ADDR_W  SRAM address
- sram_wdata  out  DATA_W  SRAM write data
- sram_be  out  DATA_W/8  SRAM byte enables
- sram_rdata  in  DATA_W  SRAM read data, valid one cycle after sram_en

## Operation
- States: IDLE, ACCESS, RESP. Reset state IDLE.
- IDLE: if m_req != 0, select winner, latch winner's we/addr/wdata/be and winner index, go ACCESS; else stay.
- ACCESS: sram_en=1, sram_* driven from latched command; m_gnt[winner]=1; go RESP.
- RESP: m_rvalid[winner]=1, m_rdata=sram_rdata (passed combinationally); writes also pulse m_rvalid; go IDLE.
- m_req sampled only in IDLE. Requester holds req and command stable until m_gnt; must drop req the cycle after m_gnt unless issuing another transaction.
- Arbitration: single request → that port wins. Both requesting → rule per Configuration.
- last_grant register updated in IDLE when a winner is chosen; reset value 1 (so port 0 wins first tie).
- m_rdata = 0 outside RESP. Port not winning sees no gnt/rvalid and must keep waiting.
- Requests arriving in ACCESS or RESP are not lost: still asserted when FSM returns to IDLE.
- Reset mid-transaction: FSM → IDLE immediately, latched command discarded, no gnt/rvalid emitted, SRAM access aborted (sram_en=0).

## Timing
- Reset values: m_gnt=0, m_rvalid=0, m_rdata=0, sram_en=0, sram_we=0, sram_addr=0, sram_wdata=0, sram_be=0, last_grant=1.
- All outputs except m_rdata registered or decoded from state/latched registers only; no combinational path from m_* inputs to any output.
- Cycle N: req sampled in IDLE. N+1: m_gnt pulse, sram_en. N+2: m_rvalid pulse with data. N+3: IDLE, next request sampled.
- Throughput: one transaction per 3 cycles. Latency req→rvalid: 2 cycles.
- sram_en never asserted in two consecutive cycles.

## Configuration
- ARB_ROUND_ROBIN_EN defined: on simultaneous requests, grant the port ≠ last_grant (strict alternation under contention).
- Not defined: fixed priority, port 0 (core) always wins ties; last_grant still maintained but unused for arbitration.

## Structure
- Shared package mem_arb_pkg: state enum (IDLE, ACCESS, RESP), port index constants (PORT_CORE=0, PORT_AUX=1), latched command struct (we, addr, wdata, be).
- One sub-module natural: arb_pick — combinational winner select from m_req and last_grant, containing the ARB_ROUND_ROBIN_EN choice.

## Test plan
- Core read only: port 0 read addr 0x10, SRAM word 0xDEADBEEF → gnt[0] at N+1 with sram_addr=0x10, rvalid[0] at N+2 with m_rdata=0xDEADBEEF.
- Aux write: port 1 write addr 0x20, data 0x12345678, be=0xF → sram_we=1 at N+1; subsequent core read of 0x20 returns 0x12345678.
- Contention, round-robin build: both req continuously for 4 transactions → grant order 0,1,0,1; fixed-priority build → 0,0,0,0 with port 1 starved.
- Byte enables: write be=0x3 data 0xAABBCCDD over 0xFFFFFFFF → read back 0xFFFFCCDD.
- Reset in ACCESS: assert rst during ACCESS → all outputs zero immediately, no rvalid after release, FSM IDLE; held request re-issued and completes.
- Back-to-back: single port holds req for 2 transactions → gnt pulses 3 cycles apart, sram_en never high two cycles running.
